// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcode/fun fields and ALU select codes.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_R_EXE    = 4'd6,
    ST_R_WB     = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
    ST_I_EXE    = 4'd10,
    ST_I_WB     = 4'd11,
    ST_TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FUN_ADD  = 6'b100000;
  localparam logic [5:0] FUN_SUB  = 6'b100010;
  localparam logic [5:0] FUN_AND  = 6'b100100;
  localparam logic [5:0] FUN_OR   = 6'b100101;
  localparam logic [5:0] FUN_XOR  = 6'b100110;
  localparam logic [5:0] FUN_NOR  = 6'b100111;
  localparam logic [5:0] FUN_SLT  = 6'b101010;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_NOR  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  // States whose exit back to FETCH marks a completed instruction.
  function automatic logic retires_from(input state_t s);
    return s inside {ST_MEM_WB, ST_MEM_WR, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP};
  endfunction

endpackage

// File: rtl/alu_fun_decode.sv
// R-type fun field to ALU select decoder, shared with the single-cycle path.
// Optional feature macro: SLT_NOR_EN adds slt and nor to the accepted fun codes.
module alu_fun_decode
  import mc_pkg::*;
#(
  parameter int SEL_W = 3
) (
  input  logic [5:0]       fun,
  output logic [SEL_W-1:0] select,
  output logic             valid
);

  logic [2:0] code;

  always_comb begin
    code  = ALU_AND;
    valid = 1'b1;
    case (fun)
      FUN_ADD: code = ALU_ADD;
      FUN_SUB: code = ALU_SUB;
      FUN_AND: code = ALU_AND;
      FUN_OR:  code = ALU_OR;
      FUN_XOR: code = ALU_XOR;
`ifdef SLT_NOR_EN
      FUN_SLT: code = ALU_SLT;
      FUN_NOR: code = ALU_NOR;
`endif
      default: valid = 1'b0;
    endcase
  end

  // Select codes are 3 bits; wider ALU select buses carry zeros above them.
  assign select = SEL_W'(code);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM with sticky illegal flag and retired-instruction counter.
// Optional feature macro: SLT_NOR_EN (slt/nor R-type support, handled in alu_fun_decode).
module multicycle_control
  import mc_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       fun,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [SEL_W-1:0] alu_select,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output state_t           state_dbg
);

  // Memory handshake: a FETCH/MEM_RD/MEM_WR access keeps its strobes asserted
  // every cycle and completes in the first cycle mem_ready is high.

  state_t           state_q, state_d;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;
  logic [SEL_W-1:0] fun_select;
  logic             fun_valid;
  logic             retire;
  logic             unused_zero;

  // Branch zero gating is done by the datapath's PC write enable.
  assign unused_zero = zero;

  alu_fun_decode #(.SEL_W(SEL_W)) u_fun_decode (
    .fun    (fun),
    .select (fun_select),
    .valid  (fun_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_TRAP) illegal_q <= 1'b1;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    alu_select    = '0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    case (state_q)
      ST_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b01;
        alu_select = SEL_W'(ALU_ADD);
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_b  = 2'b11;
        alu_select = SEL_W'(ALU_ADD);
        case (opcode)
          OP_RTYPE:     state_d = ST_R_EXE;
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI,
          OP_ORI:       state_d = ST_I_EXE;
          default:      state_d = ST_TRAP;
        endcase
      end
      ST_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_select = SEL_W'(ALU_ADD);
        state_d    = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = ST_MEM_WB;
      end
      ST_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = ST_FETCH;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_R_EXE: begin
        alu_src_a  = 1'b1;
        alu_select = fun_select;
        state_d    = fun_valid ? ST_R_WB : ST_TRAP;
      end
      ST_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_select    = SEL_W'(ALU_SUB);
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = ST_FETCH;
      end
      ST_I_EXE: begin
        alu_src_b  = 2'b10;
        alu_select = (opcode == OP_ORI) ? SEL_W'(ALU_OR) : SEL_W'(ALU_ADD);
        state_d    = ST_I_WB;
      end
      ST_I_WB: begin
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_TRAP: state_d = ST_FETCH;
      default: state_d = ST_FETCH;
    endcase
  end

  assign retire    = retires_from(state_q) && (state_d == ST_FETCH);
  // The flag shows during the TRAP cycle itself, then stays via the sticky bit.
  assign illegal   = illegal_q | (state_q == ST_TRAP);
  assign retired   = retired_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control: per-cycle state/strobe/counter vectors
// plus hand sequences for async reset mid-access and the slt configuration split.
module tb_multicycle_control;
  import mc_pkg::*;

  typedef logic [16:0] ctrl_t; // pw pwc iord mr mw irw rd m2r rw asa | asb | pcs | sel

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        mr;
    state_t      st;
    ctrl_t       c;
    logic        ill;
    logic [15:0] ret;
    bit          chk_c;
  } vec_t;

  localparam int EW = 4 + 17 + 1 + 16;

  localparam ctrl_t C_FETCH_W = 17'b0001000000_01_00_010;
  localparam ctrl_t C_FETCH_G = 17'b1001010000_01_00_010;
  localparam ctrl_t C_DECODE  = 17'b0000000000_11_00_010;
  localparam ctrl_t C_MADDR   = 17'b0000000001_10_00_010;
  localparam ctrl_t C_MRD     = 17'b0011000000_00_00_000;
  localparam ctrl_t C_MWR     = 17'b0010100000_00_00_000;
  localparam ctrl_t C_MWB     = 17'b0000000110_00_00_000;
  localparam ctrl_t C_REXE    = 17'b0000000001_00_00_000; // OR in the select code
  localparam ctrl_t C_RWB     = 17'b0000001010_00_00_000;
  localparam ctrl_t C_BR      = 17'b0100000000_00_01_110;
  localparam ctrl_t C_JMP     = 17'b1000000000_00_10_000;
  localparam ctrl_t C_IEXE    = 17'b0000000000_10_00_000; // OR in the select code
  localparam ctrl_t C_IWB     = 17'b0000000010_00_00_000;
  localparam ctrl_t C_TRAP    = 17'b0;

  logic        clk, rst;
  logic [5:0]  opcode, fun;
  logic        zero, mem_ready;
  logic [2:0]  alu_select, w2_alu_select;
  logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, pc_source;
  logic        illegal;
  logic [15:0] retired;
  state_t      state_dbg;
  logic        w2_pc_write, w2_pc_write_cond, w2_iord, w2_mem_read, w2_mem_write, w2_ir_write;
  logic        w2_reg_dst, w2_mem_to_reg, w2_reg_write, w2_alu_src_a;
  logic [1:0]  w2_alu_src_b, w2_pc_source;
  logic        w2_illegal;
  logic [1:0]  w2_retired;
  state_t      w2_state_dbg;
  ctrl_t       act_ctrl;

  int tests_run = 0;
  int tests_failed = 0;
  vec_t vecs[$];
  logic [EW-1:0] exp_q[$];

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .fun(fun), .zero(zero), .mem_ready(mem_ready),
    .alu_select(alu_select), .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .illegal(illegal), .retired(retired),
    .state_dbg(state_dbg)
  );

  multicycle_control #(.SEL_W(3), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .opcode(opcode), .fun(fun), .zero(zero), .mem_ready(mem_ready),
    .alu_select(w2_alu_select), .pc_write(w2_pc_write), .pc_write_cond(w2_pc_write_cond),
    .iord(w2_iord), .mem_read(w2_mem_read), .mem_write(w2_mem_write), .ir_write(w2_ir_write),
    .reg_dst(w2_reg_dst), .mem_to_reg(w2_mem_to_reg), .reg_write(w2_reg_write),
    .alu_src_a(w2_alu_src_a), .alu_src_b(w2_alu_src_b), .pc_source(w2_pc_source),
    .illegal(w2_illegal), .retired(w2_retired), .state_dbg(w2_state_dbg)
  );

  assign act_ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst,
                     mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source, alu_select};

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic [5:0] op, input logic [5:0] fn, input logic mr,
                               input state_t st, input ctrl_t c, input logic ill,
                               input logic [15:0] ret, input bit chk_c);
    vec_t v;
    v.op = op; v.fn = fn; v.mr = mr; v.st = st; v.c = c; v.ill = ill; v.ret = ret;
    v.chk_c = chk_c;
    return v;
  endfunction

  // FETCH with an immediately ready memory, then DECODE.
  task automatic fd(input logic [5:0] op, input logic [5:0] fn, input logic ill,
                    input logic [15:0] ret);
    vecs.push_back(mkv(op, fn, 1'b1, ST_FETCH, C_FETCH_G, ill, ret, 1'b1));
    vecs.push_back(mkv(op, fn, 1'b1, ST_DECODE, C_DECODE, ill, ret, 1'b1));
  endtask

  task automatic score(input bit chk_c);
    logic [EW-1:0] e;
    e = exp_q.pop_front();
    chk("state", state_dbg, e[37:34]);
    if (chk_c) chk("ctrl", act_ctrl, e[33:17]);
    chk("illegal", illegal, e[16]);
    chk("retired", retired, e[15:0]);
    chk("retired_w2", w2_retired, e[1:0]);
  endtask

  // Driver: one vector per clock, inputs at negedge, outputs sampled 1ns later.
  task automatic step(input vec_t v);
    @(negedge clk);
    opcode    = v.op;
    fun       = v.fn;
    mem_ready = v.mr;
    zero      = ~zero;
    exp_q.push_back({v.st, v.c, v.ill, v.ret});
    #1;
    score(v.chk_c);
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    rst = 1'b1; opcode = 6'd0; fun = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    #2;
    chk("rst_state", state_dbg, ST_FETCH);
    chk("rst_retired", retired, 16'd0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_ctrl", act_ctrl, C_FETCH_W);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // lw with memory always ready: 5 cycles back to FETCH
    fd(OP_LW, 6'd0, 1'b0, 16'd0);
    vecs.push_back(mkv(OP_LW, 6'd0, 1'b1, ST_MEM_ADDR, C_MADDR, 1'b0, 16'd0, 1'b1));
    vecs.push_back(mkv(OP_LW, 6'd0, 1'b1, ST_MEM_RD, C_MRD, 1'b0, 16'd0, 1'b1));
    vecs.push_back(mkv(OP_LW, 6'd0, 1'b1, ST_MEM_WB, C_MWB, 1'b0, 16'd0, 1'b1));
    // R-type sub
    fd(OP_RTYPE, FUN_SUB, 1'b0, 16'd1);
    vecs.push_back(mkv(OP_RTYPE, FUN_SUB, 1'b1, ST_R_EXE, C_REXE | 17'b110, 1'b0, 16'd1, 1'b1));
    vecs.push_back(mkv(OP_RTYPE, FUN_SUB, 1'b1, ST_R_WB, C_RWB, 1'b0, 16'd1, 1'b1));
    // sw: one FETCH wait, then MEM_WR held 3 extra cycles
    vecs.push_back(mkv(OP_SW, 6'd0, 1'b0, ST_FETCH, C_FETCH_W, 1'b0, 16'd2, 1'b1));
    fd(OP_SW, 6'd0, 1'b0, 16'd2);
    vecs.push_back(mkv(OP_SW, 6'd0, 1'b1, ST_MEM_ADDR, C_MADDR, 1'b0, 16'd2, 1'b1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mkv(OP_SW, 6'd0, 1'b0, ST_MEM_WR, C_MWR, 1'b0, 16'd2, 1'b1));
    vecs.push_back(mkv(OP_SW, 6'd0, 1'b1, ST_MEM_WR, C_MWR, 1'b0, 16'd2, 1'b1));
    // beq, j
    fd(OP_BEQ, 6'd0, 1'b0, 16'd3);
    vecs.push_back(mkv(OP_BEQ, 6'd0, 1'b1, ST_BRANCH, C_BR, 1'b0, 16'd3, 1'b1));
    fd(OP_J, 6'd0, 1'b0, 16'd4);
    vecs.push_back(mkv(OP_J, 6'd0, 1'b1, ST_JUMP, C_JMP, 1'b0, 16'd4, 1'b1));
    // addi, ori
    fd(OP_ADDI, 6'd0, 1'b0, 16'd5);
    vecs.push_back(mkv(OP_ADDI, 6'd0, 1'b1, ST_I_EXE, C_IEXE | 17'b010, 1'b0, 16'd5, 1'b1));
    vecs.push_back(mkv(OP_ADDI, 6'd0, 1'b1, ST_I_WB, C_IWB, 1'b0, 16'd5, 1'b1));
    fd(OP_ORI, 6'd0, 1'b0, 16'd6);
    vecs.push_back(mkv(OP_ORI, 6'd0, 1'b1, ST_I_EXE, C_IEXE | 17'b001, 1'b0, 16'd6, 1'b1));
    vecs.push_back(mkv(OP_ORI, 6'd0, 1'b1, ST_I_WB, C_IWB, 1'b0, 16'd6, 1'b1));
    // illegal opcode: TRAP, flag sticks, count frozen
    fd(6'b111111, 6'd0, 1'b0, 16'd7);
    vecs.push_back(mkv(6'b111111, 6'd0, 1'b1, ST_TRAP, C_TRAP, 1'b1, 16'd7, 1'b1));
    fd(OP_RTYPE, FUN_AND, 1'b1, 16'd7);
    vecs.push_back(mkv(OP_RTYPE, FUN_AND, 1'b1, ST_R_EXE, C_REXE | 17'b000, 1'b1, 16'd7, 1'b1));
    vecs.push_back(mkv(OP_RTYPE, FUN_AND, 1'b1, ST_R_WB, C_RWB, 1'b1, 16'd7, 1'b1));
    fd(OP_RTYPE, FUN_XOR, 1'b1, 16'd8);
    vecs.push_back(mkv(OP_RTYPE, FUN_XOR, 1'b1, ST_R_EXE, C_REXE | 17'b011, 1'b1, 16'd8, 1'b1));
    vecs.push_back(mkv(OP_RTYPE, FUN_XOR, 1'b1, ST_R_WB, C_RWB, 1'b1, 16'd8, 1'b1));
    vecs.push_back(mkv(OP_RTYPE, FUN_XOR, 1'b0, ST_FETCH, C_FETCH_W, 1'b1, 16'd9, 1'b1));
    run_vecs();

    // lw stalled in MEM_RD, then async reset abandons it
    fd(OP_LW, 6'd0, 1'b1, 16'd9);
    vecs.push_back(mkv(OP_LW, 6'd0, 1'b0, ST_MEM_ADDR, C_MADDR, 1'b1, 16'd9, 1'b1));
    vecs.push_back(mkv(OP_LW, 6'd0, 1'b0, ST_MEM_RD, C_MRD, 1'b1, 16'd9, 1'b1));
    vecs.push_back(mkv(OP_LW, 6'd0, 1'b0, ST_MEM_RD, C_MRD, 1'b1, 16'd9, 1'b1));
    run_vecs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_state", state_dbg, ST_FETCH);
    chk("midrst_retired", retired, 16'd0);
    chk("midrst_retired_w2", w2_retired, 2'd0);
    chk("midrst_illegal", illegal, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    vecs.push_back(mkv(OP_LW, 6'd0, 1'b0, ST_FETCH, C_FETCH_W, 1'b0, 16'd0, 1'b1));
    fd(OP_J, 6'd0, 1'b0, 16'd0);
    vecs.push_back(mkv(OP_J, 6'd0, 1'b1, ST_JUMP, C_JMP, 1'b0, 16'd0, 1'b1));
    // slt: accepted only with the optional R-type extension
    fd(OP_RTYPE, FUN_SLT, 1'b0, 16'd1);
`ifdef SLT_NOR_EN
    vecs.push_back(mkv(OP_RTYPE, FUN_SLT, 1'b1, ST_R_EXE, C_REXE | 17'b111, 1'b0, 16'd1, 1'b1));
    vecs.push_back(mkv(OP_RTYPE, FUN_SLT, 1'b1, ST_R_WB, C_RWB, 1'b0, 16'd1, 1'b1));
    vecs.push_back(mkv(OP_RTYPE, FUN_SLT, 1'b0, ST_FETCH, C_FETCH_W, 1'b0, 16'd2, 1'b1));
`else
    vecs.push_back(mkv(OP_RTYPE, FUN_SLT, 1'b1, ST_R_EXE, C_REXE, 1'b0, 16'd1, 1'b0));
    vecs.push_back(mkv(OP_RTYPE, FUN_SLT, 1'b1, ST_TRAP, C_TRAP, 1'b1, 16'd1, 1'b1));
    vecs.push_back(mkv(OP_RTYPE, FUN_SLT, 1'b0, ST_FETCH, C_FETCH_W, 1'b1, 16'd1, 1'b1));
`endif
    run_vecs();

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter SEL_W, default 3, meaning ALU select width (>=3, upper bits zero).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning retired-instruction counter width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-004 The block SHALL have these ports:
- opcode  in  6  IR[31:26]
- fun  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory handshake; an access completes in a cycle where it is high
- alu_select  out  SEL_W  ALU operation
- pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a  out  1 each  datapath strobes
- alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 shifted imm
- pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target
- illegal  out  1  sticky illegal-instruction flag
- retired  out  CNT_W  completed-instruction count

Function
REQ-005 The FSM SHALL have states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXE, R_WB, BRANCH, JUMP, I_EXE, I_WB, TRAP.
REQ-006 FETCH SHALL assert mem_read, iord=0, alu_src_a=0, alu_src_b=01, alu op add; it SHALL hold while mem_ready=0; on mem_ready=1 it SHALL pulse ir_write and pc_write for that cycle and go to DECODE.
REQ-007 DECODE SHALL compute the branch target (alu_src_b=11, add) and dispatch on opcode:
- 000000 -> R_EXE
- 100011 (lw), 101011 (sw) -> MEM_ADDR
- 000100 (beq) -> BRANCH
- 000010 (j) -> JUMP
- 001000 (addi), 001101 (ori) -> I_EXE
- any other -> TRAP
REQ-008 MEM_ADDR SHALL select alu_src_a=1, alu_src_b=10, add, then go to MEM_RD for lw or MEM_WR for sw.
REQ-009 MEM_RD and MEM_WR SHALL assert iord=1 with mem_read or mem_write respectively and hold until mem_ready=1; MEM_RD then goes to MEM_WB; MEM_WR then goes to FETCH.
REQ-010 MEM_WB SHALL assert reg_write with mem_to_reg=1, reg_dst=0, then go to FETCH.
REQ-011 R_EXE SHALL select alu_src_a=1, alu_src_b=00 and decode fun: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 100110 -> 011.
REQ-012 An unlisted fun in R_EXE SHALL go to TRAP; otherwise R_EXE SHALL go to R_WB.
REQ-013 R_WB and I_WB SHALL assert reg_write with mem_to_reg=0, using reg_dst=1 for R_WB and reg_dst=0 for I_WB, then go to FETCH.
REQ-014 BRANCH SHALL select sub (110), assert pc_write_cond with pc_source=01, then go to FETCH; the PC updates only when zero=1, and that gating is external.
REQ-015 JUMP SHALL assert pc_write with pc_source=10, then go to FETCH.
REQ-016 I_EXE SHALL select alu_src_b=10 with add for addi or or (001) for ori, then go to I_WB.
REQ-017 TRAP SHALL set illegal=1 for one state cycle, increment nothing, and go to FETCH; illegal SHALL remain set until reset.
REQ-018 The non-R alu_select mapping SHALL be add 010, sub 110, or 001, and SHALL be zero-extended to SEL_W.
REQ-019 retired SHALL increment by 1 on each transition into FETCH from MEM_WB, MEM_WR, R_WB, I_WB, BRANCH or JUMP, and SHALL wrap modulo 2^CNT_W.
REQ-020 All outputs except retired and illegal SHALL be combinational Moore functions of state, except the FETCH strobes qualified by mem_ready; strobes not listed for a state SHALL be 0.

Reset
REQ-021 While rst=1, the FSM SHALL be FETCH, retired SHALL be 0 and illegal SHALL be 0, immediately and asynchronously.
REQ-022 An rst asserted mid-instruction, including during a mem_ready wait, SHALL abandon the instruction without incrementing retired.

Configuration
REQ-023 With SLT_NOR_EN defined, R_EXE SHALL also accept fun 101010 (slt) -> 111 and 100111 (nor) -> 100.
REQ-024 Without SLT_NOR_EN, fun 101010 and 100111 SHALL go to TRAP.

Structure
REQ-025 The state encoding, opcode constants, fun constants and ALU select codes SHALL live in a shared package (mc_pkg).
REQ-026 fun-to-select decoding SHALL be a sub-module alu_fun_decode (fun -> select, valid), also reused by the single-cycle path.

Verification
REQ-027 The bench SHALL cover reset then lw with mem_ready=1 always: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, FETCH in 5 cycles; retired=1.
REQ-028 The bench SHALL cover an R-type with fun=100010: R_EXE alu_select=110, R_WB reg_dst=1, reg_write=1.
REQ-029 The bench SHALL cover sw with mem_ready held low 3 cycles: MEM_WR holds mem_write=1 for 4 cycles; retired increments once.
REQ-030 The bench SHALL cover opcode 111111: TRAP, illegal=1 sticky, retired unchanged, next state FETCH.
REQ-031 The bench SHALL cover fun=101010 with and without SLT_NOR_EN: alu_select=111 versus TRAP with illegal=1.
REQ-032 The bench SHALL cover rst pulsed during MEM_RD wait: state goes to FETCH and retired returns to 0; with CNT_W=2, 5 retirements yield retired=1.
